// File: rtl/mux4_rr_arbiter_if.sv
// Bus between the four requesters and the round-robin mux arbiter.
// The master side is the requester pool (drives req/din); the slave side
// is the arbiter (drives grant, selects, busy and the muxed data).
interface mux4_rr_arbiter_if #(
  parameter int DW = 1
);
  logic [3:0]      req;
  logic [4*DW-1:0] din;
  logic [3:0]      gnt;
  logic            s1;
  logic            s0;
  logic            busy;
  logic [DW-1:0]   dout;

  modport master (
    output req,
    output din,
    input  gnt,
    input  s1,
    input  s0,
    input  busy,
    input  dout
  );

  modport slave (
    input  req,
    input  din,
    output gnt,
    output s1,
    output s0,
    output busy,
    output dout
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux channel among four requesters.
// Grant, selects and busy are registered; dout is the lane picked by the
// registered selects, forced to zero when nobody owns the channel.
// Optional owner preemption after MAX_HOLD cycles is built only when the
// macro MUX_ARB_HOLD_TIMEOUT_EN is defined.
module mux4_rr_arbiter #(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mux4_rr_arbiter_if.slave   bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic [2:0] pick;

`ifdef MUX_ARB_HOLD_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
`endif

  // Search req starting just after 'after', wrapping 3 -> 0. The 'after'
  // slot itself is only eligible when incl is set (IDLE arbitration).
  // Returns {found, index}; the closest slot in rotation order wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] after,
                                         input logic       incl);
    logic [2:0] result;
    logic [1:0] idx;
    result = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = after + 2'(k);
      if (r[idx] && ((k != 4) || incl)) begin
        result = {1'b1, idx};
      end
    end
    return result;
  endfunction

  // Next-state logic: arbitrate from IDLE, hand over on release (or on
  // timeout when built in), otherwise keep the current owner stable.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    pick    = 3'b000;
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
        hold_cnt_d = '0;
`endif
        pick = rr_pick(bus.req, ptr_q, 1'b1);
        if (pick[2]) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick[1:0];
          sel_d   = pick[1:0];
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q]) begin
          ptr_d = sel_q;
          pick  = rr_pick(bus.req, sel_q, 1'b0);
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
          if (pick[2]) begin
            gnt_d = 4'b0001 << pick[1:0];
            sel_d = pick[1:0];
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
          end
        end
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
        else if ((hold_cnt_q == HOLD_LAST) && ((bus.req & ~gnt_q) != 4'b0000)) begin
          ptr_d      = sel_q;
          pick       = rr_pick(bus.req, sel_q, 1'b0);
          gnt_d      = 4'b0001 << pick[1:0];
          sel_d      = pick[1:0];
          hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; async reset releases the channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.s1   = sel_q[1];
  assign bus.s0   = sel_q[0];
  assign bus.busy = busy_q;

  // Data path: selected lane while owned, zero when the channel is free.
  always_comb begin
    bus.dout = '0;
    if (busy_q) begin
      bus.dout = bus.din[sel_q*DW +: DW];
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with DW=8 and MAX_HOLD=4.
// Expected values are hand-derived from the arbitration rules.
module tb_mux4_rr_arbiter;

  logic clk;
  logic rst_n;
  int   vecCount;
  int   missCount;

  mux4_rr_arbiter_if #(.DW(8)) bus ();

  mux4_rr_arbiter #(.DW(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
    end
  endtask

  // Drive a request vector, let one edge pass, settle just after it.
  task automatic applyStimulus(input logic [3:0] r);
    bus.req = r;
    @(posedge clk);
    #1;
  endtask

  // Main directed sequence.
  initial begin
    vecCount  = 0;
    missCount = 0;
    rst_n     = 1'b0;
    bus.req   = 4'b1111;
    bus.din   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

    // Reset holds everything idle even with all requests up.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_gnt",  32'(bus.gnt), 32'h0);
    checkOutput("rst_sel",  32'({bus.s1, bus.s0}), 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_dout", 32'(bus.dout), 32'h0);
    rst_n = 1'b1;

    // First grant after reset goes to requester 0 (ptr starts at 3).
    applyStimulus(4'b1111);
    checkOutput("first_gnt",  32'(bus.gnt), 32'h1);
    checkOutput("first_busy", 32'(bus.busy), 32'h1);
    checkOutput("first_dout", 32'(bus.dout), 32'hA0);

    // Rotation: each owner drops its bit for one edge.
    applyStimulus(4'b1110);
    checkOutput("rot_gnt1",  32'(bus.gnt), 32'h2);
    checkOutput("rot_busy1", 32'(bus.busy), 32'h1);
    applyStimulus(4'b1101);
    checkOutput("rot_gnt2",  32'(bus.gnt), 32'h4);
    checkOutput("rot_busy2", 32'(bus.busy), 32'h1);
    applyStimulus(4'b1011);
    checkOutput("rot_gnt3",  32'(bus.gnt), 32'h8);
    checkOutput("rot_sel3",  32'({bus.s1, bus.s0}), 32'h3);
    applyStimulus(4'b0111);
    checkOutput("rot_gnt0",  32'(bus.gnt), 32'h1);
    checkOutput("rot_busy0", 32'(bus.busy), 32'h1);
    applyStimulus(4'b0000);
    checkOutput("idle_gnt",  32'(bus.gnt), 32'h0);
    checkOutput("idle_busy", 32'(bus.busy), 32'h0);
    checkOutput("idle_sel",  32'({bus.s1, bus.s0}), 32'h0);

    // Wrap: requester 2 releases, 3 wins, then 3 releases and 0 wins.
    applyStimulus(4'b0100);
    checkOutput("wrap_gnt2", 32'(bus.gnt), 32'h4);
    applyStimulus(4'b1001);
    checkOutput("wrap_gnt3", 32'(bus.gnt), 32'h8);
    checkOutput("wrap_sel3", 32'({bus.s1, bus.s0}), 32'h3);
    applyStimulus(4'b0001);
    checkOutput("wrap_gnt0", 32'(bus.gnt), 32'h1);
    checkOutput("wrap_sel0", 32'({bus.s1, bus.s0}), 32'h0);
    applyStimulus(4'b0000);

    // Data path follows the selected lane combinationally.
    applyStimulus(4'b0100);
    checkOutput("dp_sel",  32'({bus.s1, bus.s0}), 32'h2);
    checkOutput("dp_dout", 32'(bus.dout), 32'hC2);
    bus.din[23:16] = 8'h5A;
    #1;
    checkOutput("dp_follow", 32'(bus.dout), 32'h5A);
    bus.din[23:16] = 8'hC2;
    applyStimulus(4'b0000);
    checkOutput("dp_rel_gnt",  32'(bus.gnt), 32'h0);
    checkOutput("dp_rel_busy", 32'(bus.busy), 32'h0);
    checkOutput("dp_rel_dout", 32'(bus.dout), 32'h0);

    // Hold timeout: requester 0 owns, requester 1 waits.
    applyStimulus(4'b0001);
    checkOutput("to_grant", 32'(bus.gnt), 32'h1);
    repeat (3) applyStimulus(4'b0011);
    checkOutput("to_before", 32'(bus.gnt), 32'h1);
    applyStimulus(4'b0011);
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
    checkOutput("to_edge", 32'(bus.gnt), 32'h2);
`else
    checkOutput("to_edge", 32'(bus.gnt), 32'h1);
`endif
    applyStimulus(4'b0000);

    // Mid-grant async reset drops the channel immediately.
    applyStimulus(4'b0100);
    checkOutput("mr_gnt", 32'(bus.gnt), 32'h4);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_gnt_rst",  32'(bus.gnt), 32'h0);
    checkOutput("mr_busy_rst", 32'(bus.busy), 32'h0);
    checkOutput("mr_dout_rst", 32'(bus.dout), 32'h0);
    #1;
    rst_n = 1'b1;
    applyStimulus(4'b0100);
    checkOutput("mr_regrant", 32'(bus.gnt), 32'h4);
    checkOutput("mr_busy",    32'(bus.busy), 32'h1);

    // Reset restores ptr=3, so requester 0 beats requester 3.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    applyStimulus(4'b1001);
    checkOutput("ptr_rst_gnt", 32'(bus.gnt), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
